edit_port_arbiter: RTL and testbench

EDIT_PORT_ARBITER -- requirements
Module: edit_port_arbiter

---
 rtl/edit_pkg.sv | 81 ++++++++
 rtl/bcd_step.sv | 29 ++
 rtl/edit_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_edit_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edit_pkg.sv
// Shared constants, field table and FSM state type for the keyboard edit port arbiter.
package edit_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StWrVal,
        StWrPtr
    } state_t;

    localparam int unsigned NumFields = 9;
    localparam logic [3:0]  LastIdx   = 4'd8;

    // PS/2 scancodes
    localparam logic [7:0] KeyEnter = 8'h5A;
    localparam logic [7:0] KeyUp    = 8'h75;
    localparam logic [7:0] KeyDown  = 8'h72;
    localparam logic [7:0] KeyRight = 8'h74;
    localparam logic [7:0] KeyLeft  = 8'h6B;
    localparam logic [7:0] KeyBreak = 8'hF0;

    // Port IDs
    localparam logic [7:0] PortPtr   = 8'h0E;
    localparam logic [7:0] PortFirst = 8'h02;
    localparam logic [7:0] PortLast  = 8'h0A;

    // BCD range limits
    localparam logic [7:0] Bcd00 = 8'h00;
    localparam logic [7:0] Bcd01 = 8'h01;
    localparam logic [7:0] Bcd12 = 8'h12;
    localparam logic [7:0] Bcd23 = 8'h23;
    localparam logic [7:0] Bcd31 = 8'h31;
    localparam logic [7:0] Bcd59 = 8'h59;
    localparam logic [7:0] Bcd99 = 8'h99;

    function automatic logic [7:0] field_port(input logic [3:0] idx);
        return PortFirst + {4'h0, idx};
    endfunction

    function automatic logic [7:0] field_ptr(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h21;
            4'd1:    return 8'h22;
            4'd2:    return 8'h23;
            4'd3:    return 8'h24;
            4'd4:    return 8'h25;
            4'd5:    return 8'h26;
            4'd6:    return 8'h41;
            4'd7:    return 8'h42;
            default: return 8'h43;
        endcase
    endfunction

    function automatic logic [7:0] field_min(input logic [3:0] idx);
        case (idx)
            4'd3, 4'd4: return Bcd01;
            default:    return Bcd00;
        endcase
    endfunction

    function automatic logic [7:0] field_max(input logic [3:0] idx);
        case (idx)
            4'd2, 4'd8: return Bcd23;
            4'd3:       return Bcd31;
            4'd4:       return Bcd12;
            4'd5:       return Bcd99;
            default:    return Bcd59;
        endcase
    endfunction

    // Day and month cannot be zero, so they power up at 01.
    function automatic logic [7:0] shadow_init(input logic [3:0] idx);
        return (idx == 4'd3 || idx == 4'd4) ? Bcd01 : Bcd00;
    endfunction

    function automatic logic is_key(input logic [7:0] code);
        return code == KeyEnter || code == KeyUp || code == KeyDown ||
               code == KeyRight || code == KeyLeft;
    endfunction

endpackage

// File: rtl/bcd_step.sv
// Two-digit BCD up/down step with wrap-around inside [min, max].
module bcd_step (
    input  logic [7:0] value,
    input  logic [7:0] min,
    input  logic [7:0] max,
    input  logic       dir,
    output logic [7:0] next_value
);

    logic valid;

    // Invalid or out-of-range values snap to min regardless of direction.
    always_comb begin
        valid = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value >= min) && (value <= max);
        next_value = min;
        if (valid) begin
            if (dir) begin
                if (value == max)            next_value = min;
                else if (value[3:0] == 4'd9) next_value = {value[7:4] + 4'd1, 4'h0};
                else                         next_value = value + 8'd1;
            end else begin
                if (value == min)            next_value = max;
                else if (value[3:0] == 4'd0) next_value = {value[7:4] - 4'd1, 4'h9};
                else                         next_value = value - 8'd1;
            end
        end
    end

endmodule

// File: rtl/edit_port_arbiter.sv
// Keyboard field editor sharing the display register write port with the CPU.
module edit_port_arbiter
    import edit_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY_STB,
    input  logic [7:0] TecladoREG,
    input  logic [7:0] TecladoREG_ANTERIOR,
    input  logic       CPU_WS,
    input  logic [7:0] CPU_ID,
    input  logic [7:0] CPU_DATA,
    output logic       WRITE_STROBE,
    output logic [7:0] POR_ID,
    output logic [7:0] OUT_PORT,
    output logic       EDIT_MODE,
    output logic       BUSY
);

    state_t     state_q, state_d;
    logic       edit_q, edit_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] code_q, code_d;
    logic [7:0] val_q, val_d;
    logic       ws_q, ws_d;
    logic [7:0] id_q, id_d;
    logic [7:0] dat_q, dat_d;
    logic [7:0] shadow_q [NumFields];
    logic [7:0] shadow_d [NumFields];

    logic       accept;
    logic       ed_val_wr;
    logic       cpu_hit;
    logic [3:0] cpu_slot;
    logic [7:0] step_value;

    bcd_step u_bcd_step (
        .value      (shadow_q[idx_q]),
        .min        (field_min(idx_q)),
        .max        (field_max(idx_q)),
        .dir        (code_q == KeyUp),
        .next_value (step_value)
    );

    assign cpu_hit  = CPU_WS && (CPU_ID >= PortFirst) && (CPU_ID <= PortLast);
    assign cpu_slot = CPU_ID[3:0] - 4'd2;
    // Outside edit mode only enter is meaningful.
    assign accept   = KEY_STB && (TecladoREG_ANTERIOR != KeyBreak) && is_key(TecladoREG) &&
                      (edit_q || TecladoREG == KeyEnter);

    // Next-state, arbitration and merged-port selection; CPU always wins the port.
    always_comb begin
        state_d   = state_q;
        edit_d    = edit_q;
        idx_d     = idx_q;
        code_d    = code_q;
        val_d     = val_q;
        ws_d      = 1'b0;
        id_d      = id_q;
        dat_d     = dat_q;
        ed_val_wr = 1'b0;
        if (CPU_WS) begin
            ws_d  = 1'b1;
            id_d  = CPU_ID;
            dat_d = CPU_DATA;
        end
        case (state_q)
            StIdle: begin
                if (accept) begin
                    code_d  = TecladoREG;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                unique case (code_q)
                    KeyEnter: begin
                        edit_d = !edit_q;
                        if (!edit_q) idx_d = 4'd0;
                        state_d = StWrPtr;
                    end
                    KeyRight: begin
                        idx_d   = (idx_q == LastIdx) ? 4'd0 : idx_q + 4'd1;
                        state_d = StWrPtr;
                    end
                    KeyLeft: begin
                        idx_d   = (idx_q == 4'd0) ? LastIdx : idx_q - 4'd1;
                        state_d = StWrPtr;
                    end
                    KeyUp, KeyDown: begin
                        val_d   = step_value;
                        state_d = StWrVal;
                    end
                    default: state_d = StIdle;
                endcase
            end
            StWrVal: begin
                if (!CPU_WS) begin
                    ws_d      = 1'b1;
                    id_d      = field_port(idx_q);
                    dat_d     = val_q;
                    ed_val_wr = 1'b1;
                    state_d   = StIdle;
                end
            end
            StWrPtr: begin
                if (!CPU_WS) begin
                    ws_d    = 1'b1;
                    id_d    = PortPtr;
                    dat_d   = edit_q ? field_ptr(idx_q) : 8'h00;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Shadow copies follow every write to the field ports from either source.
    always_comb begin
        shadow_d = shadow_q;
        if (cpu_hit)   shadow_d[cpu_slot] = CPU_DATA;
        if (ed_val_wr) shadow_d[idx_q]    = val_q;
    end

    // Control state and registered merged port.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            edit_q  <= 1'b0;
            idx_q   <= 4'd0;
            code_q  <= 8'h00;
            val_q   <= 8'h00;
            ws_q    <= 1'b0;
            id_q    <= 8'h00;
            dat_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            edit_q  <= edit_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            val_q   <= val_d;
            ws_q    <= ws_d;
            id_q    <= id_d;
            dat_q   <= dat_d;
        end
    end

    // Shadow register bank.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NumFields; i++) shadow_q[i] <= shadow_init(4'(i));
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign WRITE_STROBE = ws_q;
    assign POR_ID       = id_q;
    assign OUT_PORT     = dat_q;
    assign EDIT_MODE    = edit_q;
    assign BUSY         = (state_q != StIdle);

endmodule

// File: tb/tb_edit_port_arbiter.sv
// Directed and randomized check of edit_port_arbiter against a decimal-arithmetic model.
module tb_edit_port_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       KEY_STB = 1'b0;
    logic [7:0] TecladoREG = 8'h00;
    logic [7:0] TecladoREG_ANTERIOR = 8'h00;
    logic       CPU_WS = 1'b0;
    logic [7:0] CPU_ID = 8'h00;
    logic [7:0] CPU_DATA = 8'h00;
    logic       WRITE_STROBE;
    logic [7:0] POR_ID;
    logic [7:0] OUT_PORT;
    logic       EDIT_MODE;
    logic       BUSY;

    edit_port_arbiter dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .KEY_STB             (KEY_STB),
        .TecladoREG          (TecladoREG),
        .TecladoREG_ANTERIOR (TecladoREG_ANTERIOR),
        .CPU_WS              (CPU_WS),
        .CPU_ID              (CPU_ID),
        .CPU_DATA            (CPU_DATA),
        .WRITE_STROBE        (WRITE_STROBE),
        .POR_ID              (POR_ID),
        .OUT_PORT            (OUT_PORT),
        .EDIT_MODE           (EDIT_MODE),
        .BUSY                (BUSY)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Captured writes {POR_ID, OUT_PORT}, sampled on the falling edge.
    logic [15:0] got [$];
    logic [15:0] exp_q [$];

    always @(negedge CLK) begin
        if (RST && WRITE_STROBE === 1'b1) got.push_back({POR_ID, OUT_PORT});
    end

    // Reference model: field table and decimal range arithmetic.
    int ptr_tab  [9] = '{'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h41, 'h42, 'h43};
    int port_tab [9] = '{2, 3, 4, 5, 6, 7, 8, 9, 10};
    int lo_tab   [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    int hi_tab   [9] = '{59, 59, 23, 31, 12, 99, 59, 59, 23};
    logic [7:0] m_shadow [9];
    bit m_edit;
    int m_idx;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [7:0] model_step(input logic [7:0] v, input int lo, input int hi,
                                              input bit up);
        int d;
        if (v[7:4] > 9 || v[3:0] > 9) return to_bcd(lo);
        d = v[7:4] * 10 + v[3:0];
        if (d < lo || d > hi) return to_bcd(lo);
        if (up) d = (d == hi) ? lo : d + 1;
        else    d = (d == lo) ? hi : d - 1;
        return to_bcd(d);
    endfunction

    task automatic model_reset();
        m_edit = 0;
        m_idx  = 0;
        for (int i = 0; i < 9; i++) m_shadow[i] = (i == 3 || i == 4) ? 8'h01 : 8'h00;
    endtask

    task automatic model_cpu(input logic [7:0] id, input logic [7:0] d);
        exp_q.push_back({id, d});
        if (id >= 2 && id <= 10) m_shadow[id - 2] = d;
    endtask

    task automatic model_key(input logic [7:0] code, input logic [7:0] ant);
        logic [7:0] v;
        if (ant == 8'hF0) return;
        if (!(code inside {8'h5A, 8'h75, 8'h72, 8'h74, 8'h6B})) return;
        if (!m_edit && code != 8'h5A) return;
        case (code)
            8'h5A: begin
                m_edit = !m_edit;
                if (m_edit) m_idx = 0;
                exp_q.push_back({8'h0E, m_edit ? 8'(ptr_tab[m_idx]) : 8'h00});
            end
            8'h74: begin
                m_idx = (m_idx + 1) % 9;
                exp_q.push_back({8'h0E, 8'(ptr_tab[m_idx])});
            end
            8'h6B: begin
                m_idx = (m_idx + 8) % 9;
                exp_q.push_back({8'h0E, 8'(ptr_tab[m_idx])});
            end
            default: begin
                v = model_step(m_shadow[m_idx], lo_tab[m_idx], hi_tab[m_idx], code == 8'h75);
                m_shadow[m_idx] = v;
                exp_q.push_back({8'(port_tab[m_idx]), v});
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cpu_write(input logic [7:0] id, input logic [7:0] d);
        CPU_WS = 1'b1; CPU_ID = id; CPU_DATA = d;
        tick();
        CPU_WS = 1'b0;
        model_cpu(id, d);
    endtask

    task automatic key(input logic [7:0] code, input logic [7:0] ant);
        KEY_STB = 1'b1; TecladoREG = code; TecladoREG_ANTERIOR = ant;
        tick();
        KEY_STB = 1'b0;
        model_key(code, ant);
    endtask

    // Exactly one write seen since the last flush, equal to a fixed value.
    task automatic expect_one(input string tag, input logic [15:0] w);
        check({tag, "_cnt"}, 16'(got.size()), 16'd1);
        if (got.size() > 0) check(tag, got[0], w);
        got.delete();
        exp_q.delete();
    endtask

    task automatic expect_model(input string tag);
        int n;
        check({tag, "_cnt"}, 16'(got.size()), 16'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) check(tag, got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        model_reset();
        idle(3);
        check("rst_ws",   16'(WRITE_STROBE), 16'd0);
        check("rst_id",   16'(POR_ID),       16'h00);
        check("rst_data", 16'(OUT_PORT),     16'h00);
        check("rst_edit", 16'(EDIT_MODE),    16'd0);
        check("rst_busy", 16'(BUSY),         16'd0);
        RST = 1'b1;
        idle(2);

        // Enter edit mode
        key(8'h5A, 8'h00);
        idle(4);
        check("enter_edit", 16'(EDIT_MODE), 16'd1);
        expect_one("enter_ptr", 16'h0E21);
        check("hold_id", 16'(POR_ID), 16'h0E);

        // Index wrap both ways
        key(8'h6B, 8'h00); idle(4);
        expect_one("left_wrap", 16'h0E43);
        key(8'h74, 8'h00); idle(4);
        expect_one("right_wrap", 16'h0E21);

        // Seconds wrap at 59
        cpu_write(8'h02, 8'h59); idle(2);
        expect_one("cpu_w02", 16'h0259);
        key(8'h75, 8'h00); idle(4);
        expect_one("up_max", 16'h0200);
        key(8'h72, 8'h00); idle(4);
        expect_one("down_min", 16'h0259);

        // Move to month field
        for (int i = 1; i <= 4; i++) begin
            key(8'h74, 8'h00); idle(4);
            expect_one("move_right", 16'h0E21 + 16'(i));
        end
        cpu_write(8'h06, 8'h12); idle(2);
        expect_one("cpu_w06", 16'h0612);
        key(8'h75, 8'h00); idle(4);
        expect_one("month_up_max", 16'h0601);
        cpu_write(8'h06, 8'h1A); idle(2);
        expect_one("cpu_w06_bad", 16'h061A);
        key(8'h72, 8'h00); idle(4);
        expect_one("month_down_invalid", 16'h0601);

        // Editor write blocked by three CPU cycles
        key(8'h75, 8'h00);
        CPU_WS = 1'b1;
        for (int i = 0; i < 3; i++) begin
            CPU_ID = 8'h10 + 8'(i); CPU_DATA = 8'hA0 + 8'(i);
            tick();
            check("busy_hold", 16'(BUSY), 16'd1);
        end
        CPU_WS = 1'b0;
        idle(3);
        check("blk_cnt", 16'(got.size()), 16'd4);
        if (got.size() == 4) begin
            check("blk_cpu0", got[0], 16'h10A0);
            check("blk_cpu1", got[1], 16'h11A1);
            check("blk_cpu2", got[2], 16'h12A2);
            check("blk_ed",   got[3], 16'h0602);
        end
        check("blk_busy_done", 16'(BUSY), 16'd0);
        got.delete(); exp_q.delete();

        // Break code ignored
        key(8'h75, 8'hF0); idle(4);
        check("break_none", 16'(got.size()), 16'd0);

        // Second event during BUSY dropped
        key(8'h75, 8'h00);
        key(8'h75, 8'h00);
        idle(4);
        got.delete();
        exp_q.delete();
        m_shadow[4] = 8'h03;
        check("drop_shadow", 16'(dut.shadow_q[4]), 16'h0003);

        // Reset during WR_VAL
        key(8'h75, 8'h00);
        tick();
        RST = 1'b0;
        idle(2);
        RST = 1'b1;
        idle(5);
        check("rst_abort", 16'(got.size()), 16'd0);
        check("rst_abort_edit", 16'(EDIT_MODE), 16'd0);
        got.delete(); exp_q.delete();
        model_reset();

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            logic [7:0] codes [8];
            int n;
            codes = '{8'h5A, 8'h75, 8'h72, 8'h74, 8'h6B, 8'h75, 8'h72, 8'h12};
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) begin
                cpu_write(8'($urandom_range(0, 15)),
                          ($urandom_range(0, 1) == 1) ? to_bcd($urandom_range(0, 99))
                                                      : 8'($urandom));
            end
            key(codes[$urandom_range(0, 7)], ($urandom_range(0, 7) == 0) ? 8'hF0 : 8'h00);
            idle(5);
            expect_model("rand_wr");
            check("rand_edit", 16'(EDIT_MODE), 16'(m_edit));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
